// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl
//   Unsigned 8x8 -> 16-bit multiplier sequencer built around one external,
//   combinational 4x4 multiplier. The four nibble partial products are run
//   through the shared multiplier one per cycle and accumulated with shifts.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operand handshake; a (multiplicand), b (multiplier)
//   out_valid/out_ready result handshake; z = a*b, held until taken
//   mul_a, mul_b      nibbles driven to the shared 4x4 multiplier
//   mul_z             combinational product returned by that multiplier
//
// Build option
//   MULT_EARLY_OUT_EN  skip partial products whose A or B nibble is zero;
//                      latency becomes max(1, live step count). Undefined:
//                      fixed four steps.
module mult8_seq_ctrl #(
  parameter int IN_W  = 8,
  parameter int SUB_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       a,
  input  logic [IN_W-1:0]       b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IN_W-1:0]     z,
  output logic [SUB_W-1:0]      mul_a,
  output logic [SUB_W-1:0]      mul_b,
  input  logic [2*SUB_W-1:0]    mul_z
);

  generate
    if (IN_W != 8 || SUB_W != 4) begin : g_param_check
      $error("mult8_seq_ctrl supports only IN_W=8 and SUB_W=4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  ra, rb;
  logic [15:0] acc;
  logic [15:0] acc_sum;
  logic [15:0] term;
  logic [1:0]  step;
  logic [1:0]  first_step;
  logic [1:0]  next_step;
  logic        last_step;
  logic        use_term;
  logic        accept;

  assign accept = in_valid & in_ready;

`ifdef MULT_EARLY_OUT_EN
  logic [3:0] live;
  logic [3:0] live_in;
  logic       has_next;

  // Step i uses A nibble i[0] and B nibble i[1]; a zero nibble kills the step.
  // Scanning from 3 down to 0 leaves the lowest qualifying index in place.
  // With no live step at all, step 0 still runs as a single dead cycle
  // (its product is zero) so the result appears one cycle after accept.
  always_comb begin
    live_in    = '0;
    first_step = '0;
    next_step  = step;
    has_next   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      live_in[2'(i)] = ((i[0] ? a[7:4] : a[3:0]) != '0) &&
                       ((i[1] ? b[7:4] : b[3:0]) != '0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (live_in[2'(3 - i)]) begin
        first_step = 2'(3 - i);
      end
      if ((32'(step) < (3 - i)) && live[2'(3 - i)]) begin
        next_step = 2'(3 - i);
        has_next  = 1'b1;
      end
    end
    last_step = !has_next;
    use_term  = live[step];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= '0;
    end else if (accept) begin
      live <= live_in;
    end
  end
`else
  always_comb begin
    first_step = '0;
    next_step  = step + 2'd1;
    last_step  = (step == 2'd3);
    use_term   = 1'b1;
  end
`endif

  // Partial-product weight: step0 x1, steps 1/2 x16, step3 x256.
  always_comb begin
    case (step)
      2'd0:    term = {8'h00, mul_z};
      2'd1,
      2'd2:    term = {4'h0, mul_z, 4'h0};
      default: term = {mul_z, 8'h00};
    endcase
  end

  assign acc_sum = acc + (use_term ? term : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    out_valid = (state == DONE);
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (accept) begin
          state_nxt = MUL;
        end
      end
      MUL: begin
        mul_a = step[0] ? ra[7:4] : ra[3:0];
        mul_b = step[1] ? rb[7:4] : rb[3:0];
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = !rst && out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? MUL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      acc  <= '0;
      z    <= '0;
      step <= '0;
    end else if (accept) begin
      ra   <= a;
      rb   <= b;
      acc  <= '0;
      step <= first_step;
    end else if (state == MUL) begin
      acc  <= acc_sum;
      step <= next_step;
      if (last_step) begin
        z <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: models the shared 4x4 multiplier, runs directed
// cases then a randomized stream with stalls against a queue of a*b products.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mult8_seq_ctrl #(.IN_W(8), .SUB_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z)
  );

  // External shared 4x4 multiplier
  assign mul_z = {4'h0, mul_a} * {4'h0, mul_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected cycles from accept edge to out_valid
  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
    int n;
    logic [3:0] xn [2];
    logic [3:0] yn [2];
    xn[0] = x[3:0]; xn[1] = x[7:4];
    yn[0] = y[3:0]; yn[1] = y[7:4];
    n = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (xn[i] != 0 && yn[j] != 0) n++;
`ifdef MULT_EARLY_OUT_EN
    return (n < 1) ? 1 : n;
`else
    return 4;
`endif
  endfunction

  // Starts in IDLE, one cycle after an edge; returns in IDLE the same way
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int hold);
    int lat;
    logic [15:0] p;
    p = 16'(x) * 16'(y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat(x, y));
    chk("product", z, p);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      chk("hold_z", z, p);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_valid", out_valid, 0);
    chk("z_kept", z, p);
  endtask

  logic [15:0] exp_q [$];

  initial begin
    int n, t1, t2, sent, recvd, budget;
    logic took;
    logic [15:0] e;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 0xFF*0xFF: four steps of F/F, then 0xFE01
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("ff_mul_a", mul_a, 4'hF);
      chk("ff_mul_b", mul_b, 4'hF);
      chk("ff_busy", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("ff_valid", out_valid, 1);
    chk("ff_z", z, 16'hFE01);
    chk("done_mul_a", mul_a, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Stalled consumer
    run_op(8'h12, 8'h34, 10);

    // Back-to-back with same-cycle re-accept
    in_valid = 1'b1; out_ready = 1'b1; a = 8'h0F; b = 8'hF0;
    @(posedge clk); #1;
    a = 8'hAB; b = 8'hCD;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    t1 = cyc;
    chk("b2b_z1", z, 16'h0E10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_reaccept", out_valid, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    chk("b2b_z2", z, 16'h88EF);
    chk("b2b_spacing", t2 - t1, 1 + exp_lat(8'hAB, 8'hCD));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_idle", out_valid, 0);

    // Reset during step2 of 0x99*0x77
    a = 8'h99; b = 8'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("step2_mul_a", mul_a, 4'h9);
    chk("step2_mul_b", mul_b, 4'h7);
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_mul_a", mul_a, 0);
    chk("abort_z", z, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("no_pulse", out_valid, 0);
    end
    run_op(8'h05, 8'h07, 0);

    // Zero-nibble operands
    run_op(8'h00, 8'h37, 0);
    run_op(8'h30, 8'h05, 0);
    run_op(8'h11, 8'h11, 0);

    // Random stream with stalls on both sides
    sent = 0; recvd = 0; budget = 0;
    while (recvd < 3000 && budget < 60000) begin
      if (!in_valid && sent < 3000 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      took = in_valid && in_ready;
      if (took) begin
        exp_q.push_back(16'(a) * 16'(b));
        sent++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("rand_z", z, e);
        recvd++;
      end
      @(posedge clk); #1;
      budget++;
      if (took) in_valid = 1'b0;
    end
    chk("rand_count", recvd, 3000);
    chk("rand_queue_empty", exp_q.size(), 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rand_final_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
